// File: rtl/gmii_ptp_frame_gen.sv
// GMII transmit-side generator for bursts of PTP-over-Ethernet (EtherType 0x88F7) event frames.
// Each frame is a preamble, an SFD, FRAME_LEN header/payload bytes and an optional FCS,
// followed by IFG idle cycles. The sequenceId advances once per frame.
// Optional feature macro: GMII_GEN_FCS_EN appends a 4-byte Ethernet CRC-32 after the data bytes.
module gmii_ptp_frame_gen #(
  parameter int          FRAME_LEN = 64,
  parameter int          IFG       = 12,
  parameter logic [47:0] DST_MAC   = 48'h011B19000000,
  parameter logic [47:0] SRC_MAC   = 48'h001122334455,
  parameter logic [15:0] SEQ_INIT  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] frame_cnt,
  input  logic [3:0]  msg_type,
  output logic        busy,
  output logic        done,
  output logic        sof,
  output logic [15:0] seq_id,
  output logic        gmii_txctrl,
  output logic [7:0]  gmii_txdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_FCS, S_GAP, S_DONE
  } state_t;

  localparam logic [15:0] LAST_DATA = 16'(FRAME_LEN - 1);
  localparam logic [15:0] LAST_GAP  = 16'(IFG - 1);
  localparam logic [15:0] MSG_LEN   = 16'(FRAME_LEN - 14);

  state_t      state, state_nxt;
  logic [15:0] idx, idx_nxt;
  logic [15:0] rem;
  logic [3:0]  msg_q;
  logic        seq_pending;
  logic [7:0]  txdata_nxt;

  // Header byte at data index i; every byte not listed is zero padding
  function automatic logic [7:0] data_byte(input logic [15:0] i, input logic [3:0] msg,
                                           input logic [15:0] seq);
    logic [47:0] sh;
    sh = '0;
    data_byte = 8'h00;
    if (i < 16'd6) begin
      sh = DST_MAC << (8 * i);
      data_byte = sh[47:40];
    end else if (i < 16'd12) begin
      sh = SRC_MAC << (8 * (i - 16'd6));
      data_byte = sh[47:40];
    end else begin
      case (i)
        16'd12:  data_byte = 8'h88;
        16'd13:  data_byte = 8'hF7;
        16'd14:  data_byte = {4'h0, msg};
        16'd15:  data_byte = 8'h02;
        16'd16:  data_byte = MSG_LEN[15:8];
        16'd17:  data_byte = MSG_LEN[7:0];
        16'd44:  data_byte = seq[15:8];
        16'd45:  data_byte = seq[7:0];
        default: data_byte = 8'h00;
      endcase
    end
  endfunction

`ifdef GMII_GEN_FCS_EN
  logic [31:0] crc;
  logic [31:0] fcs_word;

  // Reflected CRC-32 advanced by one byte, LSB of the byte first
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`endif

  // Next-state and byte-index sequencing; abort overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          idx_nxt   = '0;
          state_nxt = (frame_cnt != 16'd0) ? S_PRE : S_DONE;
        end
      end
      S_PRE: begin
        if (idx == 16'd6) begin
          state_nxt = S_SFD;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 16'd1;
        end
      end
      S_SFD: begin
        state_nxt = S_DATA;
        idx_nxt   = '0;
      end
      S_DATA: begin
        if (idx == LAST_DATA) begin
`ifdef GMII_GEN_FCS_EN
          state_nxt = S_FCS;
`else
          state_nxt = S_GAP;
`endif
          idx_nxt = '0;
        end else begin
          idx_nxt = idx + 16'd1;
        end
      end
`ifdef GMII_GEN_FCS_EN
      S_FCS: begin
        if (idx == 16'd3) begin
          state_nxt = S_GAP;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 16'd1;
        end
      end
`endif
      S_GAP: begin
        if (idx == LAST_GAP) begin
          idx_nxt   = '0;
          state_nxt = (rem != 16'd0) ? S_PRE : S_DONE;
        end else begin
          idx_nxt = idx + 16'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
    end
  end

  // Byte that will be on TXD next cycle, derived from where the sequencer is heading
  always_comb begin
    txdata_nxt = 8'h00;
`ifdef GMII_GEN_FCS_EN
    fcs_word = ~crc >> {idx_nxt[1:0], 3'b000};
`endif
    case (state_nxt)
      S_PRE:  txdata_nxt = 8'h55;
      S_SFD:  txdata_nxt = 8'hD5;
      S_DATA: txdata_nxt = data_byte(idx_nxt, msg_q, seq_id);
`ifdef GMII_GEN_FCS_EN
      S_FCS:  txdata_nxt = fcs_word[7:0];
`endif
      default: txdata_nxt = 8'h00;
    endcase
  end

  // State register and registered GMII/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sof         <= 1'b0;
      gmii_txctrl <= 1'b0;
      gmii_txdata <= 8'h00;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      busy        <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done        <= (state_nxt == S_DONE);
      sof         <= (state_nxt == S_SFD);
      gmii_txctrl <= state_nxt inside {S_PRE, S_SFD, S_DATA, S_FCS};
      gmii_txdata <= txdata_nxt;
    end
  end

  // Burst bookkeeping: a frame that is cut short still consumes its sequenceId,
  // but the bump is deferred to the next accepted start so seq_id keeps showing the truncated frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      msg_q       <= '0;
      seq_id      <= SEQ_INIT;
      seq_pending <= 1'b0;
    end else begin
      if (state == S_IDLE && state_nxt == S_PRE) begin
        rem   <= frame_cnt;
        msg_q <= msg_type;
        if (seq_pending) begin
          seq_id      <= seq_id + 16'd1;
          seq_pending <= 1'b0;
        end
      end
      if (state_nxt == S_GAP && state != S_GAP) begin
        rem    <= rem - 16'd1;
        seq_id <= seq_id + 16'd1;
      end
      if (abort && (state inside {S_PRE, S_SFD, S_DATA, S_FCS})) begin
        seq_pending <= 1'b1;
      end
    end
  end

`ifdef GMII_GEN_FCS_EN
  // CRC restarts with each preamble and absorbs every data byte as it is sent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '1;
    end else if (state_nxt == S_PRE) begin
      crc <= '1;
    end else if (state_nxt == S_DATA) begin
      crc <= crc_byte(crc, txdata_nxt);
    end
  end
`endif

endmodule

// File: doc/gmii_ptp_frame_gen.md
Name: gmii_ptp_frame_gen

Overview:
Synthesisable, parametrised GMII transmit-side frame generator that emits a burst of PTP-over-Ethernet (EtherType 0x88F7) event frames. It supersedes the fixed behavioural GMII stimulus models. Frame length, inter-frame gap, MAC addresses and burst count are configurable, and sequenceId increments automatically. It drives the ha1588 rx/tx GMII timestamp inputs in simulation and on-board loopback. A start-of-frame strobe lets checkers correlate each frame with its captured RTC timestamp.

Parameters:
FRAME_LEN, 64, bytes from destination MAC to end of payload, excluding FCS; legal range 46..1514
IFG, 12, idle cycles between frames (gmii_txctrl=0); legal range 1..255
DST_MAC, 48'h011B19000000, destination MAC address, MSB byte sent first
SRC_MAC, 48'h001122334455, source MAC address, MSB byte sent first
SEQ_INIT, 16'h0000, sequenceId of the first frame after reset

Ports:
clk  input  1  generator clock (GMII tx clock domain)
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
abort  input  1  terminate the current burst immediately
frame_cnt  input  16  number of frames in the burst; latched on accepted start
msg_type  input  4  PTP messageType; latched on accepted start
busy  output  1  high from accepted start until done or abort
done  output  1  one-cycle pulse when a burst completes normally
sof  output  1  one-cycle pulse aligned with the SFD byte of each frame
seq_id  output  16  sequenceId of the frame currently or most recently sent
gmii_txctrl  output  1  GMII TX_EN
gmii_txdata  output  8  GMII TXD

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sof=0, gmii_txctrl=0, gmii_txdata=8'h00, seq_id=SEQ_INIT. All outputs are registered.
- States: IDLE -> PRE -> SFD -> DATA -> [FCS] -> GAP -> (PRE | DONE) -> IDLE.
- IDLE: start=1 with frame_cnt!=0 latches frame_cnt and msg_type, sets busy, and enters PRE. The first preamble byte appears in the next cycle, so latency from start is 1 cycle. start=1 with frame_cnt=0 gives done=1 in the next cycle, with busy and gmii_txctrl staying 0. start outside IDLE is ignored.
- PRE: 7 cycles of 8'h55, gmii_txctrl=1.
- SFD: 1 cycle of 8'hD5, gmii_txctrl=1, sof=1.
- DATA: FRAME_LEN cycles, byte index i=0..FRAME_LEN-1:
  - 0-5: DST_MAC; 6-11: SRC_MAC; 12-13: 88,F7
  - 14: {4'h0,msg_type}; 15: 8'h02
  - 16-17: messageLength = FRAME_LEN-14, big-endian
  - 44-45: seq_id, big-endian
  - all other bytes: 8'h00
- GAP: IFG cycles with gmii_txctrl=0 and gmii_txdata=8'h00. seq_id increments by 1, wrapping 16'hFFFF->16'h0000, on the first GAP cycle. A remaining-frame counter decrements there.
  - Counter nonzero after the last GAP cycle: go to PRE.
  - Counter zero: go to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- abort=1 in any non-IDLE state:
  - next cycle: gmii_txctrl=0, busy=0, state=IDLE, no done pulse.
  - seq_id keeps the value of the truncated frame.
  - abort in IDLE has no effect.
  - abort and start in the same cycle in IDLE: abort wins and start is dropped.
- gmii_txctrl is never deasserted inside PRE..DATA/FCS except by abort or reset.

Optional Feature:
GMII_GEN_FCS_EN:
- Defined: an FCS state follows DATA and emits the 4-byte Ethernet CRC-32 of bytes 0..FRAME_LEN-1, least-significant byte first, with gmii_txctrl=1.
  - Polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement.
  - The CRC register is computed byte-serially during DATA.
- Undefined: there is no FCS state; DATA goes directly to GAP. Frame length on the wire = 8+FRAME_LEN bytes.

Test Plan:
- Reset mid-burst: assert rst_n=0 during DATA -> all outputs 0 and seq_id=SEQ_INIT immediately; a fresh start afterwards produces the first preamble 1 cycle later.
- Single frame: start, frame_cnt=1, msg_type=0, defaults -> 7x55, D5 with sof=1, bytes 12-13=88 F7, 16-17=00 32, 44-45=00 00.
  - FCS macro on: 4 CRC bytes, then 12 idle cycles, done pulse, busy low.
  - Checker recomputes the CRC.
- Burst: frame_cnt=3, msg_type=1, IFG=12 -> three frames with sequenceId 0,1,2; byte 14=01; exactly 12 gmii_txctrl=0 cycles between frames; 3 sof pulses; one done.
- Wrap: SEQ_INIT=16'hFFFF, frame_cnt=2 -> sequenceIds FFFF then 0000.
- Abort: assert abort at DATA byte 20 of frame 1 of 4 -> gmii_txctrl=0 next cycle, busy=0, no done; a later start with frame_cnt=1 works, with sequenceId equal to the aborted frame's seq_id+1.
- Edge cases:
  - start with frame_cnt=0 -> done after 1 cycle, no GMII activity.
  - start asserted while busy -> ignored; burst length unchanged.
